// File: rtl/booth_multiplier_seq.sv
// Sequential signed Booth multiplier: one recoding step per clock with a
// start/busy/done handshake.
// Build option: define BOOTH_RADIX4_EN for radix-4 (modified Booth) recoding,
// which takes WIDTH/2 steps. Without it the unit uses radix-2 and takes WIDTH
// steps. Both builds produce bit-identical results.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request; operands are sampled when start=1 and the block is not busy
//   M      signed multiplicand (WIDTH bits)
//   q      signed multiplier (WIDTH bits)
//   busy   high while computing (state RUN)
//   done   one-cycle pulse marking a new result on z
//   z      signed product M*q (2*WIDTH bits); holds until the next done
module booth_multiplier_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

`ifdef BOOTH_RADIX4_EN
  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned AW    = WIDTH + 2;
`else
  localparam int unsigned STEPS = WIDTH;
  localparam int unsigned AW    = WIDTH + 1;
`endif
  localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [AW-1:0]    a_reg;
  logic             qm1;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_step;
  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    a_step;
  logic [WIDTH-1:0] q_step;
  logic             qm1_step;

  assign accept    = start && (state != S_RUN);
  assign last_step = (cnt == CW'(STEPS - 1));
  assign m_ext     = {{(AW-WIDTH){m_reg[WIDTH-1]}}, m_reg};

  // One Booth recoding step followed by the arithmetic shift of {A,Q,q[-1]}.
  always_comb begin
    addend = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q_reg[1:0], qm1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum      = a_reg + addend;
    a_step   = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_step   = {sum[1:0], q_reg[WIDTH-1:2]};
    qm1_step = q_reg[1];
`else
    case ({q_reg[0], qm1})
      2'b01:   addend = m_ext;
      2'b10:   addend = -m_ext;
      default: addend = '0;
    endcase
    sum      = a_reg + addend;
    a_step   = {sum[AW-1], sum[AW-1:1]};
    q_step   = {sum[0], q_reg[WIDTH-1:1]};
    qm1_step = q_reg[0];
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a start in DONE chains straight into the next run.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load on accept, step while running, publish z on the final step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_reg <= '0;
      q_reg <= '0;
      a_reg <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      z     <= '0;
    end else if (accept) begin
      m_reg <= M;
      q_reg <= q;
      a_reg <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_reg <= a_step;
      q_reg <= q_step;
      qm1   <= qm1_step;
      cnt   <= cnt + CW'(1);
      // Guard bits are pure sign extension here; the product fits 2*WIDTH.
      if (last_step) z <= {a_step[WIDTH-1:0], q_step};
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq (WIDTH=8): reset, directed
// corner table, handshake sequences and a random back-to-back stream checked
// against plain signed multiplication.
module tb_booth_multiplier_seq;

`ifdef BOOTH_RADIX4_EN
  localparam int L = 4;
`else
  localparam int L = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  m_op;
  logic [7:0]  q_op;
  logic        busy;
  logic        done;
  logic [15:0] z;

  int total = 0;
  int bad   = 0;

  booth_multiplier_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M(m_op), .q(q_op),
    .busy(busy), .done(done), .z(z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] expq[$];

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa * sb);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Ticks until done is seen; n returns the number of edges taken (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
  endtask

  // Single operation with latency, busy-length, result and pulse-width checks.
  task automatic run_op(input logic [7:0] m, input logic [7:0] qv,
                        input logic [15:0] exp, input string name);
    int n;
    int bc;
    m_op = m; q_op = qv; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      tick();
      n++;
    end
    check({name, " latency"}, n, L);
    check({name, " busy cycles"}, bc, L);
    check({name, " z"}, int'(z), int'(exp));
    tick();
    check({name, " done width"}, int'(done), 0);
  endtask

  initial begin
    int n;
    int dcnt;
    logic [7:0] rm;
    logic [7:0] rq;

    vecs[0] = '{8'd3,    8'd21,   16'h003F};
    vecs[1] = '{8'h80,   8'h80,   16'd16384};
    vecs[2] = '{8'hFF,   8'd127,  16'hFF81};
    vecs[3] = '{8'd13,   8'hF9,   16'hFFA5};   // 13 * -7 = -91
    vecs[4] = '{8'd0,    8'h80,   16'h0000};
    vecs[5] = '{8'h80,   8'd127,  16'hC080};   // -16256
    vecs[6] = '{8'd127,  8'd127,  16'd16129};
    vecs[7] = '{8'h80,   8'd1,    16'hFF80};

    rst_n = 1'b0; start = 1'b0; m_op = '0; q_op = '0;
    tick(); tick();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset z", int'(z), 0);
    rst_n = 1'b1;
    tick();

    // Basic op and result hold.
    run_op(8'd3, 8'd21, 16'd63, "basic");
    repeat (5) tick();
    check("basic hold z", int'(z), 63);
    check("basic hold done", int'(done), 0);

    // Directed corner table.
    foreach (vecs[i]) run_op(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));

    // Start while busy is ignored.
    m_op = 8'd2; q_op = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    m_op = 8'd5; q_op = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0;
    repeat (L + 10) begin
      if (done) dcnt++;
      tick();
    end
    check("busy-protect done count", dcnt, 1);
    check("busy-protect z", int'(z), 4);

    // Back-to-back with start held high.
    m_op = 8'd3; q_op = 8'd11; start = 1'b1;
    tick();
    wait_done(n);
    check("b2b first latency", n, L);
    check("b2b first z", int'(z), 33);
    m_op = 8'd3; q_op = 8'd40;
    wait_done(n);
    start = 1'b0;
    check("b2b gap", n, L + 1);
    check("b2b second z", int'(z), 120);
    tick();

    // Reset during an operation discards it.
    m_op = 8'd13; q_op = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset z", int'(z), 0);
    dcnt = 0;
    repeat (L + 4) begin
      if (done) dcnt++;
      tick();
    end
    check("midreset no done", dcnt, 0);
    run_op(8'd13, 8'd7, 16'd91, "after reset");

    // Random back-to-back stream against a queue of expected products.
    rm = 8'($urandom); rq = 8'($urandom);
    m_op = rm; q_op = rq; start = 1'b1;
    expq.push_back(model(rm, rq));
    tick();
    for (int i = 0; i < 2000; i++) begin
      wait_done(n);
      check($sformatf("rand%0d latency", i), n, (i == 0) ? L : L + 1);
      if (expq.size() > 0) check($sformatf("rand%0d z", i), int'(z), int'(expq.pop_front()));
      else check($sformatf("rand%0d scoreboard", i), 1, 0);
      if (i < 1999) begin
        rm = 8'($urandom); rq = 8'($urandom);
        m_op = rm; q_op = rq;
        expq.push_back(model(rm, rq));
      end else begin
        start = 1'b0;
      end
    end
    tick();
    check("rand done width", int'(done), 0);
    check("rand leftover", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
